dm_arb: RTL and testbench
=========================

DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 SHALL have parameter AW, default 9: DM byte-address width (512-byte DM).
REQ-002 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_req / m1_req  input  1 each: access request; requester holds the request and its fields stable until it sees gnt.
REQ-005 SHALL have ports m0_we / m1_we  input  1 each: 1 = store, 0 = load.
REQ-006 SHALL have ports m0_op / m1_op  input  3 each: funct3 access code.
REQ-007 SHALL have ports m0_addr / m1_addr  input  AW each: byte address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  32 each: store data, LSB-aligned.
REQ-009 SHALL have ports m0_gnt / m1_gnt  output  1 each: one-cycle pulse; request consumed.
REQ-010 SHALL have ports m0_err / m1_err  output  1 each: one-cycle pulse, coincident with gnt; request rejected.
REQ-011 SHALL have ports m0_rvalid / m1_rvalid  output  1 each: one-cycle pulse; load data valid.
REQ-012 SHALL have ports m0_rdata / m1_rdata  output  32 each: load result; held until that port's next rvalid.
REQ-013 SHALL have ports dm_read / dm_write  output  1 each: DM strobes.
REQ-014 SHALL have ports dmop  output  3, dm_addr  output  AW, dm_din  output  32: DM command fields.
REQ-015 SHALL have port dm_dout  input  32: DM load data, registered in the DM and valid in the cycle after the dm_read cycle.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: if any req is high, SHALL pick a winner, latch its we/op/addr/wdata and port id, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the port not granted last wins; a single request wins unconditionally.
REQ-019 The last-granted pointer SHALL update on every grant, including rejected requests.
REQ-020 ISSUE: SHALL pulse the winner's gnt and drive dmop/dm_addr/dm_din from the latches.
REQ-021 ISSUE: SHALL assert dm_write for a legal store, or dm_read for a legal load, for exactly this cycle.
REQ-022 ISSUE exit: legal load SHALL go to WAIT; store or rejected request SHALL go to IDLE.
REQ-023 WAIT: SHALL capture dm_dout into the winner's rdata register at the end of the cycle, then go to RESP.
REQ-024 RESP: SHALL pulse the winner's rvalid for one cycle, then go to IDLE.
REQ-025 Legal load ops SHALL be 000, 001, 010, 100 and 101; legal store ops SHALL be 000, 001 and 010.
REQ-026 Alignment: halfword ops (x01) SHALL require addr[0]=0; word op 010 SHALL require addr[1:0]=00.
REQ-027 An illegal op or a misaligned address SHALL be rejected: err pulses with gnt, no DM strobe, no rvalid.
REQ-028 Latency SHALL be: req seen in IDLE cycle N, gnt at N+1, dm_dout valid at N+2, rvalid at N+3.
REQ-029 Throughput SHALL be one load per 4 cycles and one store per 2 cycles.
REQ-030 req SHALL be sampled only in IDLE; a req still high in IDLE after its gnt SHALL be treated as a new request.
REQ-031 Outside ISSUE, dm_read and dm_write SHALL be 0; dmop/dm_addr/dm_din SHALL hold their latched values.
REQ-032 At most one gnt, one err and one rvalid SHALL be high in any cycle.

Reset
REQ-033 rstn low SHALL asynchronously force state IDLE.
REQ-034 rstn low SHALL clear all gnt/err/rvalid/rdata and dm_read/dm_write/dmop/dm_addr/dm_din to 0.
REQ-035 rstn low SHALL set the last-granted pointer to m1, so m0 wins the first contention.
REQ-036 Reset in ISSUE, WAIT or RESP SHALL abort the access with no further strobe or rvalid; a DM write already clocked is not undone.

Verification
REQ-037 Reset, then m0 store op 010, addr 0x010, wdata 0xDEADBEEF -> m0_gnt and dm_write high in one cycle with dmop 010, dm_addr 0x010, dm_din 0xDEADBEEF; FSM back in IDLE next cycle.
REQ-038 m1 load op 010, addr 0x010 after that store -> m1_rvalid 3 cycles after req sampled, m1_rdata 0xDEADBEEF; m0 outputs stay 0.
REQ-039 m0 and m1 request continuously from reset -> grant order m0, m1, m0, m1; never two gnts in one cycle.
REQ-040 m0 load op 010, addr 0x006; then m1 store op 011 -> each: gnt+err pulse, dm_read/dm_write stay 0, no rvalid.
REQ-041 Reset asserted in WAIT of an m0 load -> all outputs 0 immediately; no m0_rvalid; after release, m0 wins contention against m1.

Source files
------------

// File: rtl/dm_arb.sv
// dm_arb: two-master round-robin arbiter in front of the data memory.
// One access in flight at a time; alignment and funct3 legality checked here.
module dm_arb #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [2:0]    m0_op,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [2:0]    m1_op,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m0_gnt,
    output logic          m0_err,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m1_gnt,
    output logic          m1_err,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          dm_read,
    output logic          dm_write,
    output logic [2:0]    dmop,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    input  logic [31:0]   dm_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   last;
    logic   sel;
    logic   lat_ld;

    logic          win;
    logic          w_we;
    logic [2:0]    w_op;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_wdata;
    logic          op_ok;
    logic          al_ok;
    logic          ok;

    // Only m1 asking, or both asking with m0 granted last, selects m1.
    always_comb begin
        win     = m1_req & (~m0_req | ~last);
        w_we    = win ? m1_we    : m0_we;
        w_op    = win ? m1_op    : m0_op;
        w_addr  = win ? m1_addr  : m0_addr;
        w_wdata = win ? m1_wdata : m0_wdata;
        if (w_we)
            op_ok = (w_op == 3'b000) | (w_op == 3'b001) | (w_op == 3'b010);
        else
            op_ok = (w_op == 3'b000) | (w_op == 3'b001) | (w_op == 3'b010)
                  | (w_op == 3'b100) | (w_op == 3'b101);
        al_ok = 1'b1;
        if (w_op[1:0] == 2'b01 && w_addr[0])
            al_ok = 1'b0;
        if (w_op == 3'b010 && w_addr[1:0] != 2'b00)
            al_ok = 1'b0;
        ok = op_ok & al_ok;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            last      <= 1'b1;
            sel       <= 1'b0;
            lat_ld    <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            dm_read   <= 1'b0;
            dm_write  <= 1'b0;
            dmop      <= '0;
            dm_addr   <= '0;
            dm_din    <= '0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            dm_read   <= 1'b0;
            dm_write  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m0_req | m1_req) begin
                        sel      <= win;
                        last     <= win;
                        lat_ld   <= ok & ~w_we;
                        dmop     <= w_op;
                        dm_addr  <= w_addr;
                        dm_din   <= w_wdata;
                        m0_gnt   <= ~win;
                        m1_gnt   <= win;
                        m0_err   <= ~win & ~ok;
                        m1_err   <= win & ~ok;
                        dm_read  <= ok & ~w_we;
                        dm_write <= ok & w_we;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= lat_ld ? WAIT : IDLE;
                end
                WAIT: begin
                    if (sel) begin
                        m1_rdata  <= dm_dout;
                        m1_rvalid <= 1'b1;
                    end else begin
                        m0_rdata  <= dm_dout;
                        m0_rvalid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arb.sv
// Bench for dm_arb: directed scenarios then random traffic, checked every
// cycle against a transaction-timeline model with its own byte memory.
module tb_dm_arb;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rstn;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [2:0]    m0_op, m1_op;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_err, m1_err, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          dm_read, dm_write;
    logic [2:0]    dmop;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_din;
    logic [31:0]   dm_dout = '0;

    dm_arb #(.AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m0_err(m0_err),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_gnt(m1_gnt), .m1_err(m1_err),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .dm_read(dm_read), .dm_write(dm_write), .dmop(dmop),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    logic [7:0] dm_mem  [512] = '{default: 8'h00};
    logic [7:0] ref_mem [512] = '{default: 8'h00};

    function automatic logic [31:0] mem_load(input logic [7:0] m [512],
                                             input logic [2:0] op,
                                             input int a);
        int n = 1 << op[1:0];
        logic [31:0] v = '0;
        for (int i = 0; i < 4; i++)
            if (i < n) v[8*i +: 8] = m[(a + i) % 512];
        if (!op[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!op[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic bit ref_legal(bit we, int op, int a);
        bit known = we ? (op <= 2) : (op <= 2 || op == 4 || op == 5);
        int size = 1 << (op % 4);
        return known && (a % size == 0);
    endfunction

    // Behavioural DM: synchronous write, registered load data.
    always @(posedge clk) begin
        if (dm_write)
            for (int i = 0; i < 4; i++)
                if (i < (1 << dmop[1:0]))
                    dm_mem[(int'(dm_addr) + i) % 512] <= dm_din[8*i +: 8];
        if (dm_read)
            dm_dout <= mem_load(dm_mem, dmop, int'(dm_addr));
    end

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int free_at = 0;
    bit last = 1'b1;
    logic [7:0]  ev_p [8];
    logic [31:0] ev_data [8];
    logic [7:0]  exp_p, obs_p;
    logic [43:0] exp_cmd, obs_cmd, snap_cmd;
    logic [31:0] exp_rd0, exp_rd1;
    logic        seen_g0, seen_g1, seen_e0, seen_e1, seen_rv0, seen_rv1;
    int          rv1_cyc;

    task automatic check_cycle();
        int slot = cyc % 8;
        obs_p   = {m0_gnt, m1_gnt, m0_err, m1_err,
                   m0_rvalid, m1_rvalid, dm_read, dm_write};
        obs_cmd = {dmop, dm_addr, dm_din};
        if (!rstn) begin
            for (int i = 0; i < 8; i++) ev_p[i] = '0;
            exp_p = '0; exp_cmd = '0; exp_rd0 = '0; exp_rd1 = '0;
            last = 1'b1; free_at = 0;
        end else begin
            exp_p = ev_p[slot];
            if (exp_p[3]) exp_rd0 = ev_data[slot];
            if (exp_p[2]) exp_rd1 = ev_data[slot];
            if (exp_p[0])
                for (int i = 0; i < (1 << (int'(exp_cmd[43:41]) % 4)); i++)
                    ref_mem[(int'(exp_cmd[40:32]) + i) % 512] = exp_cmd[8*i +: 8];
            ev_p[slot] = '0;
        end
        checks++;
        assert (obs_p === exp_p) else begin
            errs++;
            $error("FAIL pulses cyc=%0d obs=%b exp=%b", cyc, obs_p, exp_p);
        end
        checks++;
        assert (obs_cmd === exp_cmd) else begin
            errs++;
            $error("FAIL dmcmd cyc=%0d obs=%h exp=%h", cyc, obs_cmd, exp_cmd);
        end
        checks++;
        assert ({m0_rdata, m1_rdata} === {exp_rd0, exp_rd1}) else begin
            errs++;
            $error("FAIL rdata cyc=%0d obs=%h/%h exp=%h/%h",
                   cyc, m0_rdata, m1_rdata, exp_rd0, exp_rd1);
        end
        seen_g0 = m0_gnt; seen_g1 = m1_gnt;
        seen_e0 = m0_err; seen_e1 = m1_err;
        seen_rv0 = m0_rvalid; seen_rv1 = m1_rvalid;
        if (m0_gnt || m1_gnt) snap_cmd = {dm_write, dmop, dm_addr, dm_din[31:1]};
        if (m1_rvalid) rv1_cyc = cyc;
        // A free arbiter seeing a request commits a whole timeline of events.
        if (rstn && cyc >= free_at && (m0_req || m1_req)) begin
            bit w = (m0_req && m1_req) ? !last : m1_req;
            bit we = w ? m1_we : m0_we;
            int op = w ? int'(m1_op) : int'(m0_op);
            int a = w ? int'(m1_addr) : int'(m0_addr);
            logic [31:0] wd = w ? m1_wdata : m0_wdata;
            bit ok = ref_legal(we, op, a);
            int s1 = (cyc + 1) % 8;
            int s3 = (cyc + 3) % 8;
            ev_p[s1][7 - w] = 1'b1;
            if (!ok) ev_p[s1][5 - w] = 1'b1;
            if (ok && we) ev_p[s1][0] = 1'b1;
            if (ok && !we) begin
                ev_p[s1][1] = 1'b1;
                ev_p[s3][3 - w] = 1'b1;
                ev_data[s3] = mem_load(ref_mem, 3'(op), a);
            end
            exp_cmd = {3'(op), 9'(a), wd};
            last = w;
            free_at = cyc + ((ok && !we) ? 4 : 2);
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input bit we, input int op,
                           input int a, input logic [31:0] wd);
        if (p == 0) begin
            m0_req = 1; m0_we = we; m0_op = 3'(op);
            m0_addr = 9'(a); m0_wdata = wd;
        end else begin
            m1_req = 1; m1_we = we; m1_op = 3'(op);
            m1_addr = 9'(a); m1_wdata = wd;
        end
    endtask

    task automatic wait_gnt(input int p);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (p == 0) ? seen_g0 : seen_g1;
        end
        checks++;
        assert (got) else begin
            errs++;
            $error("FAIL gnt_timeout port=%0d obs=0 exp=1", p);
        end
        if (p == 0) m0_req = 0; else m1_req = 0;
    endtask

    int c0;
    int order[4];
    int ng;
    bit two;

    initial begin
        rstn = 0;
        m0_req = 0; m0_we = 0; m0_op = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_op = '0; m1_addr = '0; m1_wdata = '0;
        repeat (2) tick();
        rstn = 1;
        tick();

        set_req(0, 1, 2, 'h010, 32'hDEADBEEF);
        wait_gnt(0);
        checks++;
        assert (snap_cmd === {1'b1, 3'b010, 9'h010, 31'h6F56DF77}) else begin
            errs++;
            $error("FAIL store010 obs=%h exp=%h", snap_cmd,
                   {1'b1, 3'b010, 9'h010, 31'h6F56DF77});
        end

        c0 = cyc;
        set_req(1, 0, 2, 'h010, 32'h0);
        wait_gnt(1);
        for (int i = 0; i < 6 && !seen_rv1; i++) tick();
        checks++;
        assert (m1_rdata === 32'hDEADBEEF && rv1_cyc == c0 + 3) else begin
            errs++;
            $error("FAIL load_back obs=%h@%0d exp=deadbeef@%0d",
                   m1_rdata, rv1_cyc, c0 + 3);
        end
        tick();

        set_req(0, 0, 2, 'h006, 32'h0);
        wait_gnt(0);
        checks++;
        assert (seen_e0 === 1'b1) else begin
            errs++;
            $error("FAIL misalign_err obs=%b exp=1", seen_e0);
        end
        set_req(1, 1, 3, 'h000, 32'h12345678);
        wait_gnt(1);
        checks++;
        assert (seen_e1 === 1'b1) else begin
            errs++;
            $error("FAIL badop_err obs=%b exp=1", seen_e1);
        end
        repeat (4) tick();

        rstn = 0;
        set_req(0, 1, 0, 'h040, 32'h000000A5);
        set_req(1, 1, 0, 'h041, 32'h0000005A);
        tick();
        rstn = 1;
        ng = 0; two = 0;
        for (int i = 0; i < 30 && ng < 4; i++) begin
            tick();
            if (seen_g0 && seen_g1) two = 1;
            if (seen_g0 || seen_g1) begin
                order[ng] = seen_g1 ? 1 : 0;
                ng++;
            end
        end
        checks++;
        assert (ng == 4 && !two && order[0] == 0 && order[1] == 1
                && order[2] == 0 && order[3] == 1) else begin
            errs++;
            $error("FAIL rr_order obs=%0d%0d%0d%0d n=%0d dual=%0d exp=0101",
                   order[0], order[1], order[2], order[3], ng, two);
        end
        m0_req = 0; m1_req = 0;
        repeat (3) tick();

        set_req(0, 0, 2, 'h010, 32'h0);
        wait_gnt(0);
        rstn = 0;
        tick();
        checks++;
        assert ({m0_rvalid, m0_gnt, m0_rdata} === 34'h0) else begin
            errs++;
            $error("FAIL rst_wait obs=%h exp=0", {m0_rvalid, m0_gnt, m0_rdata});
        end
        set_req(0, 0, 0, 'h011, 32'h0);
        set_req(1, 0, 0, 'h012, 32'h0);
        tick();
        rstn = 1;
        wait_gnt(0);
        checks++;
        assert (seen_g1 === 1'b0) else begin
            errs++;
            $error("FAIL rst_first obs=m1 exp=m0");
        end
        wait_gnt(1);
        repeat (4) tick();

        for (int i = 0; i < 400; i++) begin
            tick();
            if (m0_req && seen_g0) m0_req = 0;
            if (m1_req && seen_g1) m1_req = 0;
            if (!m0_req && $urandom_range(0, 2) == 0)
                set_req(0, 1'($urandom), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 31)), $urandom);
            if (!m1_req && $urandom_range(0, 2) == 0)
                set_req(1, 1'($urandom), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 31)), $urandom);
        end
        m0_req = 0; m1_req = 0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
